life_grid_engine: RTL and testbench

- Parametrised Game-of-Life engine: holds a ROWS x COLS cell grid and computes generations under rule B3/S23.
- Streams one pixel write per changed cell to the VGA plotting path via a valid/ready handshake.
- Supports bounded or toroidal edges, single-cell set/clear loads, and a full-grid clear.
- Sits between the control FSM (load/step/clear pulses) and the VGA adapter (x, y, colour, plot).

---
 rtl/life_grid_engine_if.sv | 30 +++
 rtl/life_grid_engine.sv | 219 +++++++++++++++++++++
 tb/tb_life_grid_engine.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/life_grid_engine_if.sv
// Load and pixel buses of the Game-of-Life engine. The engine uses the master
// modport (it accepts loads and produces pixels); the environment uses slave.
interface life_grid_engine_if #(
    parameter int XW = 8,
    parameter int YW = 8
);
    // Both channels: a transfer happens on a rising clock edge where valid && ready;
    // the producer holds valid and its payload unchanged until that edge.
    logic          load_valid;
    logic          load_ready;
    logic [XW-1:0] load_x;
    logic [YW-1:0] load_y;
    logic          load_alive;

    logic          px_valid;
    logic          px_ready;
    logic [XW-1:0] px_x;
    logic [YW-1:0] px_y;
    logic [2:0]    px_colour;

    modport master (
        input  load_valid, load_x, load_y, load_alive, px_ready,
        output load_ready, px_valid, px_x, px_y, px_colour
    );

    modport slave (
        output load_valid, load_x, load_y, load_alive, px_ready,
        input  load_ready, px_valid, px_x, px_y, px_colour
    );
endinterface

// File: rtl/life_grid_engine.sv
// Game-of-Life (B3/S23) engine: sweeps the grid one cell per cycle and streams
// one pixel per changed cell; also handles single-cell loads and a full clear.
module life_grid_engine #(
    parameter int         ROWS    = 16,
    parameter int         COLS    = 16,
    parameter int         XW      = 8,
    parameter int         YW      = 8,
    parameter int         WRAP    = 0,
    parameter logic [2:0] C_ALIVE = 3'b111,
    parameter logic [2:0] C_DEAD  = 3'b000
) (
    input  logic                clock,
    input  logic                reset_n,
    life_grid_engine_if.master  bus,
    input  logic                step,
    input  logic                clear,
    output logic                busy,
    output logic [15:0]         gen_count,
    output logic [15:0]         alive_count,
    output logic [2:0]          dbg_state
);
    localparam int N  = ROWS * COLS;
    localparam int AW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_SCAN       = 3'd1,
        S_PXWAIT     = 3'd2,
        S_COMMIT     = 3'd3,
        S_CLR_SCAN   = 3'd4,
        S_CLR_PXWAIT = 3'd5,
        S_LD_PXWAIT  = 3'd6
    } state_t;

    state_t        state, state_n;
    logic [N-1:0]  cur, nxt;
    logic [AW-1:0] idx, idx_inc;
    logic [XW-1:0] cx, cx_inc;
    logic [YW-1:0] cy, cy_inc;
    logic [15:0]   delta;
    logic          px_valid_q;
    logic [XW-1:0] px_x_q;
    logic [YW-1:0] px_y_q;
    logic [2:0]    px_colour_q;

    logic          load_ready, load_in_range, accept_px, last;
    logic          cell_cur, new_val, changed;
    logic [3:0]    ncount;
    logic [AW-1:0] load_idx;

    // Off-grid neighbours are dead unless the grid is toroidal.
    function automatic logic nb_alive(input logic [N-1:0] g, input int x, input int y);
        int xx;
        int yy;
        xx = x;
        yy = y;
        if (WRAP != 0) begin
            if (xx < 0) xx = xx + COLS; else if (xx >= COLS) xx = xx - COLS;
            if (yy < 0) yy = yy + ROWS; else if (yy >= ROWS) yy = yy - ROWS;
        end
        if (xx < 0 || xx >= COLS || yy < 0 || yy >= ROWS) return 1'b0;
        return g[AW'(yy * COLS + xx)];
    endfunction

    always_comb begin
        ncount = '0;
        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++)
                if (dx != 0 || dy != 0)
                    ncount = ncount + {3'b000, nb_alive(cur, int'(cx) + dx, int'(cy) + dy)};
    end

    assign cell_cur      = cur[idx];
    assign new_val       = (ncount == 4'd3) | (cell_cur & (ncount == 4'd2));
    assign changed       = new_val != cell_cur;
    assign last          = (idx == AW'(N - 1));
    assign accept_px     = px_valid_q && bus.px_ready;
    assign load_ready    = (state == S_IDLE) && !px_valid_q;
    assign load_in_range = (int'(bus.load_x) < COLS) && (int'(bus.load_y) < ROWS);
    assign load_idx      = AW'(int'(bus.load_y) * COLS + int'(bus.load_x));

    // Raster-order successor; x/y are tracked alongside idx to avoid a divider.
    always_comb begin
        idx_inc = idx + AW'(1);
        cx_inc  = cx + XW'(1);
        cy_inc  = cy;
        if (cx == XW'(COLS - 1)) begin
            cx_inc = '0;
            cy_inc = cy + YW'(1);
        end
        if (last) begin
            idx_inc = '0;
            cx_inc  = '0;
            cy_inc  = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (clear)                               state_n = S_CLR_SCAN;
                else if (bus.load_valid && load_ready)   state_n = load_in_range ? S_LD_PXWAIT : S_IDLE;
                else if (step)                           state_n = S_SCAN;
            end
            S_SCAN: begin
                if (changed)   state_n = S_PXWAIT;
                else if (last) state_n = S_COMMIT;
            end
            S_PXWAIT:     if (accept_px) state_n = last ? S_COMMIT : S_SCAN;
            S_COMMIT:     state_n = S_IDLE;
            S_CLR_SCAN: begin
                if (cell_cur)  state_n = S_CLR_PXWAIT;
                else if (last) state_n = S_IDLE;
            end
            S_CLR_PXWAIT: if (accept_px) state_n = last ? S_IDLE : S_CLR_SCAN;
            S_LD_PXWAIT:  if (accept_px) state_n = S_IDLE;
            default:      state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cur         <= '0;
            nxt         <= '0;
            idx         <= '0;
            cx          <= '0;
            cy          <= '0;
            delta       <= '0;
            px_valid_q  <= 1'b0;
            px_x_q      <= '0;
            px_y_q      <= '0;
            px_colour_q <= C_DEAD;
            gen_count   <= '0;
            alive_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (clear) begin
                        idx <= '0;
                        cx  <= '0;
                        cy  <= '0;
                    end else if (bus.load_valid && load_ready) begin
                        if (load_in_range) begin
                            cur[load_idx] <= bus.load_alive;
                            if (bus.load_alive && !cur[load_idx])      alive_count <= alive_count + 16'd1;
                            else if (!bus.load_alive && cur[load_idx]) alive_count <= alive_count - 16'd1;
                            px_valid_q  <= 1'b1;
                            px_x_q      <= bus.load_x;
                            px_y_q      <= bus.load_y;
                            px_colour_q <= bus.load_alive ? C_ALIVE : C_DEAD;
                        end
                    end else if (step) begin
                        idx   <= '0;
                        cx    <= '0;
                        cy    <= '0;
                        delta <= '0;
                    end
                end
                S_SCAN: begin
                    nxt[idx] <= new_val;
                    if (changed) begin
                        px_valid_q  <= 1'b1;
                        px_x_q      <= cx;
                        px_y_q      <= cy;
                        px_colour_q <= new_val ? C_ALIVE : C_DEAD;
                        delta       <= new_val ? delta + 16'd1 : delta - 16'd1;
                    end else begin
                        idx <= idx_inc;
                        cx  <= cx_inc;
                        cy  <= cy_inc;
                    end
                end
                S_PXWAIT, S_CLR_PXWAIT: begin
                    if (accept_px) begin
                        px_valid_q <= 1'b0;
                        idx        <= idx_inc;
                        cx         <= cx_inc;
                        cy         <= cy_inc;
                    end
                end
                S_COMMIT: begin
                    cur         <= nxt;
                    gen_count   <= gen_count + 16'd1;
                    alive_count <= alive_count + delta;
                end
                S_CLR_SCAN: begin
                    if (cell_cur) begin
                        cur[idx]    <= 1'b0;
                        alive_count <= alive_count - 16'd1;
                        px_valid_q  <= 1'b1;
                        px_x_q      <= cx;
                        px_y_q      <= cy;
                        px_colour_q <= C_DEAD;
                    end else begin
                        idx <= idx_inc;
                        cx  <= cx_inc;
                        cy  <= cy_inc;
                    end
                end
                S_LD_PXWAIT: if (accept_px) px_valid_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.load_ready = load_ready;
    assign bus.px_valid   = px_valid_q;
    assign bus.px_x       = px_x_q;
    assign bus.px_y       = px_y_q;
    assign bus.px_colour  = px_colour_q;
    assign busy           = (state != S_IDLE);
    assign dbg_state      = state;
endmodule

// File: tb/tb_life_grid_engine.sv
// Directed bench: a 16x16 bounded engine and an 8x8 toroidal engine, with a
// pixel scoreboard and per-scenario counter checks.
`timescale 1ns/1ps
module tb_life_grid_engine;
    localparam int         W  = 19;
    localparam logic [2:0] CA = 3'b111;
    localparam logic [2:0] CD = 3'b000;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    logic       sel = 1'b0;
    logic       ld_valid = 1'b0;
    logic       ld_alive = 1'b0;
    logic [7:0] ld_x = '0;
    logic [7:0] ld_y = '0;
    logic       step = 1'b0;
    logic       clear = 1'b0;
    logic       px_ready = 1'b1;
    logic       bp_mode = 1'b0;

    logic        busy0, busy1;
    logic [15:0] gen0, gen1, alive0, alive1;
    logic [2:0]  st0, st1;

    life_grid_engine_if #(.XW(8), .YW(8)) ifc0 ();
    life_grid_engine_if #(.XW(8), .YW(8)) ifc1 ();

    assign ifc0.load_valid = ld_valid && !sel;
    assign ifc1.load_valid = ld_valid && sel;
    assign ifc0.load_x     = ld_x;
    assign ifc1.load_x     = ld_x;
    assign ifc0.load_y     = ld_y;
    assign ifc1.load_y     = ld_y;
    assign ifc0.load_alive = ld_alive;
    assign ifc1.load_alive = ld_alive;
    assign ifc0.px_ready   = px_ready;
    assign ifc1.px_ready   = px_ready;

    life_grid_engine #(.ROWS(16), .COLS(16), .XW(8), .YW(8), .WRAP(0)) dut0 (
        .clock(clock), .reset_n(reset_n), .bus(ifc0.master),
        .step(step && !sel), .clear(clear && !sel), .busy(busy0),
        .gen_count(gen0), .alive_count(alive0), .dbg_state(st0)
    );

    life_grid_engine #(.ROWS(8), .COLS(8), .XW(8), .YW(8), .WRAP(1)) dut1 (
        .clock(clock), .reset_n(reset_n), .bus(ifc1.master),
        .step(step && sel), .clear(clear && sel), .busy(busy1),
        .gen_count(gen1), .alive_count(alive1), .dbg_state(st1)
    );

    logic         busy_m, pxv_m, ldr_m;
    logic [15:0]  gen_m, alive_m;
    logic [2:0]   st_m;
    logic [W-1:0] px_m;
    assign busy_m  = sel ? busy1 : busy0;
    assign pxv_m   = sel ? ifc1.px_valid : ifc0.px_valid;
    assign ldr_m   = sel ? ifc1.load_ready : ifc0.load_ready;
    assign gen_m   = sel ? gen1 : gen0;
    assign alive_m = sel ? alive1 : alive0;
    assign st_m    = sel ? st1 : st0;
    assign px_m    = sel ? {ifc1.px_x, ifc1.px_y, ifc1.px_colour}
                         : {ifc0.px_x, ifc0.px_y, ifc0.px_colour};

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    logic [W-1:0] held = '0;
    logic         held_ok = 1'b0;

    // Pixels are sampled mid-cycle; a pixel seen with ready high is taken at the next edge.
    always @(negedge clock) begin
        if (reset_n && pxv_m) begin
            if (px_ready) begin
                got_q.push_back(px_m);
                held_ok = 1'b0;
            end else begin
                if (held_ok) check("px_hold", 32'(px_m), 32'(held));
                held    = px_m;
                held_ok = 1'b1;
            end
        end
    end

    int bp_cnt = 0;
    always @(posedge clock) begin
        #1;
        if (!bp_mode) px_ready = 1'b1;
        else if (pxv_m && !px_ready) begin
            if (bp_cnt == 9) begin
                px_ready = 1'b1;
                bp_cnt   = 0;
            end else bp_cnt++;
        end else px_ready = 1'b0;
    end

    task automatic push_exp(input int x, input int y, input logic [2:0] c);
        exp_q.push_back({8'(x), 8'(y), c});
    endtask

    task automatic check_px(input string tag);
        check({tag, "_npx"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0)
            check({tag, "_px"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_idle(input string tag, input int budget, output int cycles);
        cycles = 0;
        while ((busy_m || pxv_m) && cycles < budget) begin
            cycles++;
            @(posedge clock);
            #1;
        end
        check({tag, "_idle"}, {30'd0, busy_m, pxv_m}, 32'd0);
    endtask

    task automatic do_load(input int x, input int y, input logic a);
        int n;
        n = 0;
        while (!ldr_m && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
        ld_x     = 8'(x);
        ld_y     = 8'(y);
        ld_alive = a;
        ld_valid = 1'b1;
        @(posedge clock);
        #1;
        ld_valid = 1'b0;
        wait_idle("load", 20, n);
    endtask

    task automatic pulse(input logic do_step, input logic do_clear, output int cycles);
        step  = do_step;
        clear = do_clear;
        @(posedge clock);
        #1;
        step  = 1'b0;
        clear = 1'b0;
        wait_idle("pulse", 5000, cycles);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        n_errors++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_busy", busy_m, 0);
        check("rst_pxv", pxv_m, 0);
        check("rst_px", 32'(px_m), {13'd0, 16'd0, CD});
        check("rst_ready", ldr_m, 1);
        check("rst_gen", gen_m, 0);
        check("rst_alive", alive_m, 0);
        check("rst_state", st_m, 0);
        reset_n = 1'b1;

        // Vertical blinker, then two steps with free-running ready
        do_load(5, 4, 1'b1); do_load(5, 5, 1'b1); do_load(5, 6, 1'b1);
        push_exp(5, 4, CA); push_exp(5, 5, CA); push_exp(5, 6, CA);
        check_px("blink_load");
        check("blink_load_alive", alive_m, 3);

        push_exp(5, 4, CD); push_exp(4, 5, CA); push_exp(6, 5, CA); push_exp(5, 6, CD);
        pulse(1'b1, 1'b0, cyc);
        check_px("blink_step1");
        check("blink_step1_cycles", cyc, 261);
        check("blink_step1_alive", alive_m, 3);
        check("blink_step1_gen", gen_m, 1);

        push_exp(5, 4, CA); push_exp(4, 5, CD); push_exp(6, 5, CD); push_exp(5, 6, CA);
        pulse(1'b1, 1'b0, cyc);
        check_px("blink_step2");
        check("blink_step2_gen", gen_m, 2);

        // Same transition with ready held low ~10 cycles per pixel
        bp_mode = 1'b1;
        push_exp(5, 4, CD); push_exp(4, 5, CA); push_exp(6, 5, CA); push_exp(5, 6, CD);
        pulse(1'b1, 1'b0, cyc);
        bp_mode = 1'b0;
        @(posedge clock);
        #1;
        check_px("bp_step");
        check("bp_gen", gen_m, 3);
        check("bp_alive", alive_m, 3);

        // Out-of-range load, then clear reads back the live cells in raster order
        do_load(16, 3, 1'b1);
        check_px("oor");
        check("oor_alive", alive_m, 3);
        push_exp(4, 5, CD); push_exp(5, 5, CD); push_exp(6, 5, CD);
        pulse(1'b0, 1'b1, cyc);
        check_px("clear");
        check("clear_alive", alive_m, 0);
        check("clear_gen", gen_m, 3);

        // Clear and step in the same cycle: clear wins, step is dropped
        do_load(3, 3, 1'b1);
        push_exp(3, 3, CA);
        pulse(1'b1, 1'b1, cyc);
        push_exp(3, 3, CD);
        check_px("prio");
        check("prio_gen", gen_m, 3);
        check("prio_alive", alive_m, 0);

        // Corner block is a still life
        do_reset();
        do_load(0, 0, 1'b1); do_load(1, 0, 1'b1); do_load(0, 1, 1'b1); do_load(1, 1, 1'b1);
        push_exp(0, 0, CA); push_exp(1, 0, CA); push_exp(0, 1, CA); push_exp(1, 1, CA);
        check_px("block_load");
        pulse(1'b1, 1'b0, cyc);
        check_px("block_step");
        check("block_cycles", cyc, 257);
        check("block_gen", gen_m, 1);
        check("block_alive", alive_m, 4);

        // Reset in the middle of a sweep
        do_load(5, 4, 1'b1); do_load(5, 5, 1'b1); do_load(5, 6, 1'b1);
        got_q.delete();
        step = 1'b1;
        @(posedge clock);
        #1;
        step = 1'b0;
        repeat (80) @(posedge clock);
        #1;
        check("mid_busy", busy_m, 1);
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        check("mid_rst_pxv", pxv_m, 0);
        check("mid_rst_busy", busy_m, 0);
        check("mid_rst_state", st_m, 0);
        check("mid_rst_alive", alive_m, 0);
        check("mid_rst_gen", gen_m, 0);
        reset_n = 1'b1;
        got_q.delete();
        exp_q.delete();
        pulse(1'b1, 1'b0, cyc);
        check_px("post_rst_step");
        check("post_rst_cycles", cyc, 257);

        // Toroidal glider on the 8x8 engine: four generations move it by (+1,+1)
        sel = 1'b1;
        do_load(6, 0, 1'b1); do_load(7, 1, 1'b1); do_load(5, 2, 1'b1);
        do_load(6, 2, 1'b1); do_load(7, 2, 1'b1);
        push_exp(6, 0, CA); push_exp(7, 1, CA); push_exp(5, 2, CA);
        push_exp(6, 2, CA); push_exp(7, 2, CA);
        check_px("glider_load");
        for (int g = 0; g < 4; g++) begin
            pulse(1'b1, 1'b0, cyc);
            got_q.delete();
            check("glider_alive", alive_m, 5);
        end
        check("glider_gen", gen_m, 4);
        push_exp(7, 1, CD); push_exp(0, 2, CD); push_exp(0, 3, CD);
        push_exp(6, 3, CD); push_exp(7, 3, CD);
        pulse(1'b0, 1'b1, cyc);
        check_px("glider_final");
        check("glider_clear_alive", alive_m, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
